// File: rtl/abajur_scheduler_if.sv
// Pin-side bundle of the lamp scheduler: raw switches and PWM streams in, gated drives out.
interface abajur_scheduler_if;
  logic [9:0] sw;
  logic [2:0] pwm_motor_in;
  logic [3:0] pwm_led_in;
  logic [2:0] pwm_motor;
  logic [3:0] led;
  logic [1:0] motor_active;
  logic [2:0] led_mode;

  modport master (
    output sw, pwm_motor_in, pwm_led_in,
    input  pwm_motor, led, motor_active, led_mode
  );

  modport slave (
    input  sw, pwm_motor_in, pwm_led_in,
    output pwm_motor, led, motor_active, led_mode
  );
endinterface

// File: rtl/abajur_scheduler.sv
// Switch debouncer, round-robin single-motor time slicer with dead time, and LED mode selector.
// All outputs are registered; reset is synchronous and active-high.
module abajur_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SLOT_CYCLES     = 50000000,
  parameter int unsigned DEAD_CYCLES     = 1000000,
  parameter int unsigned BLINK_HALF      = 12500000
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  abajur_scheduler_if.slave  io_bus
);

  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SlotW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DeadW  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  logic [9:0]      r_sync1, r_sync2, r_db;
  logic [DebW-1:0] r_deb_cnt [10];

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int k = 0; k < 10; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync1 <= io_bus.sw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 10; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_deb_cnt[k] == DebW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[k]      <= r_sync2[k];
            r_deb_cnt[k] <= '0;
          end else begin
            r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
          end
        end else begin
          r_deb_cnt[k] <= '0;
        end
      end
    end
  end

  // Motor scheduler
  state_e           r_state, w_state_d;
  logic [1:0]       r_gnt, w_gnt_d, r_rr, w_rr_d, w_pick, w_gnt_next;
  logic [SlotW-1:0] r_slot, w_slot_d;
  logic [DeadW-1:0] r_dead, w_dead_d;
  logic [2:0]       r_pwm_motor, w_pwm_motor_d, w_req;
  logic [1:0]       r_motor_active, w_motor_active_d;
  logic             w_all_off, w_req_g, w_other;

  assign w_req      = {r_db[7], r_db[8], r_db[9]};
  assign w_all_off  = (r_db == '0);
  assign w_req_g    = w_req[r_gnt];
  assign w_other    = |(w_req & ~(3'b001 << r_gnt));
  assign w_gnt_next = (r_gnt == 2'd2) ? 2'd0 : r_gnt + 2'd1;

  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_pick = r_rr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 3; i++) begin
      idx = 2'((int'(r_rr) + i) % 3);
      if (!found && w_req[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_gnt_d          = r_gnt;
    w_rr_d           = r_rr;
    w_slot_d         = r_slot;
    w_dead_d         = r_dead;
    w_pwm_motor_d    = '0;
    w_motor_active_d = '0;
    if (w_all_off) begin
      // rr pointer deliberately survives a full switch-off
      w_state_d = StIdle;
      w_slot_d  = '0;
      w_dead_d  = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|w_req) begin
            w_state_d = StRun;
            w_gnt_d   = w_pick;
            w_slot_d  = '0;
          end
        end
        StRun: begin
          if (!w_req_g) begin
            w_state_d = StDead;
            w_dead_d  = '0;
            w_rr_d    = w_gnt_next;
          end else begin
            w_pwm_motor_d    = io_bus.pwm_motor_in & (3'b001 << r_gnt);
            w_motor_active_d = r_gnt + 2'd1;
            if (r_slot == SlotW'(SLOT_CYCLES - 1)) begin
              w_slot_d = '0;
              if (w_other) begin
                w_state_d = StDead;
                w_dead_d  = '0;
                w_rr_d    = w_gnt_next;
              end
            end else begin
              w_slot_d = r_slot + 1'b1;
            end
          end
        end
        StDead: begin
          if (r_dead == DeadW'(DEAD_CYCLES - 1)) begin
            w_state_d = StIdle;
            w_dead_d  = '0;
          end else begin
            w_dead_d = r_dead + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // LED mode priority: pwm > blink > all-on > individual > off
  logic [BlinkW-1:0] r_blink, w_blink_d;
  logic              r_phase, w_phase_d;
  logic [3:0]        r_led, w_led_d;
  logic [2:0]        r_led_mode, w_led_mode_d;

  always_comb begin
    w_led_d      = '0;
    w_led_mode_d = 3'd0;
    w_blink_d    = '0;
    w_phase_d    = 1'b0;
    if (r_db[0]) begin
      w_led_mode_d = 3'd4;
      w_led_d      = io_bus.pwm_led_in;
    end else if (r_db[1]) begin
      w_led_mode_d = 3'd3;
      w_led_d      = {4{r_phase}};
      if (r_blink == BlinkW'(BLINK_HALF - 1)) begin
        w_blink_d = '0;
        w_phase_d = ~r_phase;
      end else begin
        w_blink_d = r_blink + 1'b1;
        w_phase_d = r_phase;
      end
    end else if (r_db[2]) begin
      w_led_mode_d = 3'd2;
      w_led_d      = 4'hF;
    end else if (|r_db[6:3]) begin
      w_led_mode_d = 3'd1;
      w_led_d      = {r_db[3], r_db[4], r_db[5], r_db[6]};
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state        <= StIdle;
      r_gnt          <= '0;
      r_rr           <= '0;
      r_slot         <= '0;
      r_dead         <= '0;
      r_pwm_motor    <= '0;
      r_motor_active <= '0;
      r_blink        <= '0;
      r_phase        <= 1'b0;
      r_led          <= '0;
      r_led_mode     <= '0;
    end else begin
      r_state        <= w_state_d;
      r_gnt          <= w_gnt_d;
      r_rr           <= w_rr_d;
      r_slot         <= w_slot_d;
      r_dead         <= w_dead_d;
      r_pwm_motor    <= w_pwm_motor_d;
      r_motor_active <= w_motor_active_d;
      r_blink        <= w_blink_d;
      r_phase        <= w_phase_d;
      r_led          <= w_led_d;
      r_led_mode     <= w_led_mode_d;
    end
  end

  assign io_bus.pwm_motor    = r_pwm_motor;
  assign io_bus.motor_active = r_motor_active;
  assign io_bus.led          = r_led;
  assign io_bus.led_mode     = r_led_mode;

endmodule
